// File: rtl/cnt_ctrl_pkg.sv
// Shared constants for the digit-counter chain controller: FSM state codes and defaults.
// Imported by the debouncer and the sequencer top.
package cnt_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_CLEAR = 2'b11;

    localparam int DEB_MS_DEF  = 10;
    localparam int N_STAGE_DEF = 4;

    // States in which the chain is allowed to advance at all.
    function automatic logic st_may_advance(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter clocked by the 1 ms strobe,
// and a one-clk event on each accepted rising level.
module btn_debounce
    import cnt_ctrl_pkg::*;
#(
    parameter int DEB_MS = DEB_MS_DEF
) (
    input  logic clk,
    input  logic R_n,
    input  logic ce1ms,
    input  logic btn,
    output logic ev
);

    localparam int CW = $clog2(DEB_MS + 1);
    localparam logic [CW-1:0] DEB_LIM = CW'(DEB_MS);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_next;
    logic          ev_reg;
    logic          ev_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        level_next = level_reg;
        cnt_next   = cnt_reg;
        cnt_inc    = cnt_reg + CW'(1);
        if (ce1ms) begin
            if (sync2_reg != level_reg) begin
                // Accept the new level once it has differed for DEB_MS consecutive strobes.
                if (cnt_inc == DEB_LIM) begin
                    level_next = sync2_reg;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end else begin
                cnt_next = '0;
            end
        end
        ev_next = level_next & ~level_reg;
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            ev_reg    <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            ev_reg    <= ev_next;
        end
    end

    assign ev = ev_reg;

endmodule

// File: rtl/cnt_chain_ctrl.sv
// Run/stop/step/clear sequencer for the cascaded digit counters: debounced buttons drive a
// small FSM, and per-stage count enables are built from the tick and the stage terminal counts.
module cnt_chain_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int N_STAGE = N_STAGE_DEF,
    parameter int DEB_MS  = DEB_MS_DEF
) (
    input  logic               clk,
    input  logic               R_n,
    input  logic               ce1ms,
    input  logic               tick,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               btn_clr,
    input  logic               one_shot,
    input  logic [N_STAGE-1:0] TC,
    output logic [N_STAGE-1:0] ce_stage,
    output logic               clr,
    output logic               ovf,
    output logic               run,
    output logic [1:0]         state
);

    // Button index order: 0 = run, 1 = step, 2 = clear.
    logic [2:0] btn_raw;
    logic [2:0] btn_ev;
    logic       run_ev;
    logic       step_ev;
    logic       clr_ev;

    assign btn_raw = {btn_clr, btn_step, btn_run};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            btn_debounce #(
                .DEB_MS (DEB_MS)
            ) u_deb (
                .clk   (clk),
                .R_n   (R_n),
                .ce1ms (ce1ms),
                .btn   (btn_raw[gi]),
                .ev    (btn_ev[gi])
            );
        end
    endgenerate

    assign run_ev  = btn_ev[0];
    assign step_ev = btn_ev[1];
    assign clr_ev  = btn_ev[2];

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             clr_reg;
    logic             run_reg;
    logic             adv;
    logic [N_STAGE:0] tc_chain;

    // Enables come straight from the registered state so a tick advances the chain in its own clk.
    assign adv = st_may_advance(state_reg) & ((state_reg == ST_STEP) | tick);

    assign tc_chain[0] = 1'b1;
    generate
        for (gi = 0; gi < N_STAGE; gi++) begin : g_cascade
            assign tc_chain[gi+1] = tc_chain[gi] & TC[gi];
            assign ce_stage[gi]   = adv & tc_chain[gi];
        end
    endgenerate

    assign ovf = adv & tc_chain[N_STAGE];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_ev)       state_next = ST_CLEAR;
                else if (run_ev)  state_next = ST_RUN;
                else if (step_ev) state_next = ST_STEP;
            end
            ST_RUN: begin
                if (clr_ev)                state_next = ST_CLEAR;
                else if (run_ev)           state_next = ST_IDLE;
                else if (one_shot && ovf)  state_next = ST_IDLE;
            end
            ST_STEP:  state_next = ST_IDLE;
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_reg <= ST_IDLE;
            clr_reg   <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            clr_reg   <= (state_next == ST_CLEAR);
            run_reg   <= (state_next == ST_RUN);
        end
    end

    assign state = state_reg;
    assign clr   = clr_reg;
    assign run   = run_reg;

endmodule

// File: tb/tb_cnt_chain_ctrl.sv
// Directed bench for cnt_chain_ctrl with a short debounce and a fast 1 ms strobe.
module tb_cnt_chain_ctrl;

    localparam int N_STAGE = 4;

    logic               clk = 1'b0;
    logic               R_n = 1'b0;
    logic               ce1ms = 1'b0;
    logic               tick = 1'b0;
    logic               btn_run = 1'b0;
    logic               btn_step = 1'b0;
    logic               btn_clr = 1'b0;
    logic               one_shot = 1'b0;
    logic [N_STAGE-1:0] TC = '0;
    logic [N_STAGE-1:0] ce_stage;
    logic               clr;
    logic               ovf;
    logic               run;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int clr_cnt = 0;

    cnt_chain_ctrl #(
        .N_STAGE (N_STAGE),
        .DEB_MS  (2)
    ) dut (
        .clk      (clk),
        .R_n      (R_n),
        .ce1ms    (ce1ms),
        .tick     (tick),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_clr  (btn_clr),
        .one_shot (one_shot),
        .TC       (TC),
        .ce_stage (ce_stage),
        .clr      (clr),
        .ovf      (ovf),
        .run      (run),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (7) @(negedge clk);
            ce1ms = 1'b1;
            @(negedge clk);
            ce1ms = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (ce_stage[0]) ce_cnt++;
        if (clr) clr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {30'd0, state}, {30'd0, s});
    endtask

    initial begin
        // 1: reset with buttons and tick active
        btn_run = 1'b1; btn_step = 1'b1; tick = 1'b1; TC = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_clr", {31'd0, clr}, 32'd0);
        check("rst_ce", {28'd0, ce_stage}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        btn_run = 1'b0; btn_step = 1'b0; tick = 1'b0; TC = '0;
        R_n = 1'b1;
        repeat (20) @(negedge clk);

        // 2: short press rejected, long press gives exactly one event
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (40) @(negedge clk);
        check("short_press_idle", {30'd0, state}, 32'd0);
        btn_run = 1'b1;
        wait_state(2'b01, 60, "long_press_run");
        check("long_press_led", {31'd0, run}, 32'd1);
        repeat (40) @(negedge clk);
        check("hold_single_ev", {30'd0, state}, 32'd1);
        btn_run = 1'b0;
        repeat (40) @(negedge clk);
        check("release_no_ev", {30'd0, state}, 32'd1);

        // 3: cascade enables and wrap
        @(negedge clk); TC = 4'b0011; tick = 1'b1;
        #1 check("ce_tc0011", {28'd0, ce_stage}, 32'h7);
        check("ovf_tc0011", {31'd0, ovf}, 32'd0);
        @(negedge clk); tick = 1'b0;
        #1 check("ce_no_tick", {28'd0, ce_stage}, 32'h0);
        @(negedge clk); TC = 4'b1111;
        #1 check("ovf_no_tick", {31'd0, ovf}, 32'd0);
        @(negedge clk); tick = 1'b1;
        #1 check("ce_wrap", {28'd0, ce_stage}, 32'hF);
        check("ovf_wrap", {31'd0, ovf}, 32'd1);
        @(posedge clk); #1 check("wrap_keep_run", {30'd0, state}, 32'd1);
        @(negedge clk); tick = 1'b0; one_shot = 1'b1;
        @(negedge clk); tick = 1'b1;
        #1 check("ovf_oneshot", {31'd0, ovf}, 32'd1);
        @(posedge clk); #1 check("oneshot_idle", {30'd0, state}, 32'd0);
        check("oneshot_run_led", {31'd0, run}, 32'd0);
        check("idle_tick_ce", {28'd0, ce_stage}, 32'h0);
        check("idle_tick_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); tick = 1'b0; one_shot = 1'b0; TC = '0;

        // 4: single step
        ce_cnt = 0;
        btn_step = 1'b1;
        wait_state(2'b10, 60, "step_state");
        check("step_ce", {28'd0, ce_stage}, 32'h1);
        @(negedge clk);
        check("step_back_idle", {30'd0, state}, 32'd0);
        repeat (30) @(negedge clk);
        btn_step = 1'b0;
        repeat (40) @(negedge clk);
        check("step_ce_count", ce_cnt, 32'd1);
        check("step_final_idle", {30'd0, state}, 32'd0);

        // 5: clear wins over run when both fire together
        btn_run = 1'b1;
        wait_state(2'b01, 60, "run_again");
        repeat (30) @(negedge clk);
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        btn_run = 1'b1; btn_clr = 1'b1;
        wait_state(2'b11, 60, "clr_priority");
        check("clr_pulse", {31'd0, clr}, 32'd1);
        check("clr_run_led", {31'd0, run}, 32'd0);
        @(negedge clk);
        check("clr_to_idle", {30'd0, state}, 32'd0);
        check("clr_one_clk", {31'd0, clr}, 32'd0);
        check("clr_idle_run", {31'd0, run}, 32'd0);
        repeat (30) @(negedge clk);
        btn_run = 1'b0; btn_clr = 1'b0;
        repeat (40) @(negedge clk);
        check("clr_stay_idle", {30'd0, state}, 32'd0);
        check("clr_pulse_count", clr_cnt, 32'd1);

        // 6: asynchronous reset in the middle of RUN
        btn_run = 1'b1;
        wait_state(2'b01, 60, "run_before_rst");
        repeat (30) @(negedge clk);
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        tick = 1'b1; TC = '0;
        #1 check("pre_rst_ce", {28'd0, ce_stage}, 32'h1);
        #2 R_n = 1'b0;
        #1 check("async_rst_state", {30'd0, state}, 32'd0);
        check("async_rst_ce", {28'd0, ce_stage}, 32'h0);
        check("async_rst_run", {31'd0, run}, 32'd0);
        check("async_rst_clr", {31'd0, clr}, 32'd0);
        @(negedge clk); @(negedge clk);
        R_n = 1'b1;
        @(negedge clk); TC = 4'b1111;
        #1 check("post_rst_ce", {28'd0, ce_stage}, 32'h0);
        check("post_rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); tick = 1'b0;
        repeat (5) @(negedge clk);
        check("final_clr_count", clr_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
